// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter for the multicycle datapath.
// Updates the PC on control PC-write strobes (step, branch, jump, call, return),
// with a RUN/HALT state machine. Define PC_RAS_EN to build the return-address
// stack; without it, call behaves as jmp and ret is ignored.
module pc_sequencer #(
  parameter int N         = 5,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         pc_en,
  input  logic         br_take,
  input  logic [N-1:0] br_target,
  input  logic         jmp,
  input  logic         call,
  input  logic [N-1:0] jmp_target,
  input  logic         ret,
  input  logic         halt_req,
  input  logic         resume,
  output logic [N-1:0] newp,
  output logic         halted,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_ovf,
  output logic         ras_unf
);

  localparam logic [N-1:0] STEP_N  = N'(STEP);
  localparam logic [N-1:0] RESET_N = N'(RESET_VEC);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic         w_upd;
  logic [N-1:0] r_pc, w_pc_nxt, w_pc_inc;

  assign w_pc_inc = r_pc + STEP_N;
  assign newp     = r_pc;
  assign halted   = (r_state == S_HALT);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state; a PC update is allowed only in RUN with no halt request
  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    case (r_state)
      S_RUN:  if (halt_req) w_state_nxt = S_HALT;
              else          w_upd       = pc_en;
      S_HALT: if (resume)   w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // PC register
  always_ff @(posedge CLK) begin
    if (RST) r_pc <= RESET_N;
    else     r_pc <= w_pc_nxt;
  end

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [N-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0] r_top, w_top_inc;
  logic [PW:0]   r_cnt;
  logic          r_ovf, r_unf;
  logic          w_push, w_pop, w_unf_set;

  assign w_top_inc = r_top + 1'b1;
  assign ras_empty = (r_cnt == '0);
  assign ras_full  = (r_cnt == (PW+1)'(RAS_DEPTH));
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

  // Next PC and stack actions, first match wins: ret, call, jmp, branch, step
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_unf_set = 1'b0;
    if (w_upd) begin
      if (ret) begin
        if (!ras_empty) begin
          w_pc_nxt = r_ras[r_top];
          w_pop    = 1'b1;
        end else begin
          w_pc_nxt  = w_pc_inc;
          w_unf_set = 1'b1;
        end
      end else if (call) begin
        w_pc_nxt = jmp_target;
        w_push   = 1'b1;
      end else if (jmp)     w_pc_nxt = jmp_target;
      else if (br_take)     w_pc_nxt = br_target;
      else                  w_pc_nxt = w_pc_inc;
    end
  end

  // Circular stack: a push when full overwrites the oldest slot, count saturates
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push) begin
        r_top            <= w_top_inc;
        r_ras[w_top_inc] <= w_pc_inc;
        if (ras_full) r_ovf <= 1'b1;
        else          r_cnt <= r_cnt + 1'b1;
      end
      if (w_pop) begin
        r_top <= r_top - 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_unf_set) r_unf <= 1'b1;
    end
  end
`else
  logic w_unused_ret;
  assign w_unused_ret = ret;

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;

  // Next PC without a stack: call is a plain jump
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_upd) begin
      if (call || jmp) w_pc_nxt = jmp_target;
      else if (br_take) w_pc_nxt = br_target;
      else              w_pc_nxt = w_pc_inc;
    end
  end
`endif

endmodule
